// File: rtl/pipeline_monitor_pkg.sv
// Shared types and helpers for the pipeline event monitor.
package pipeline_monitor_pkg;

    // Monitor FSM states; IDLE is the reset state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Event channel assignments as wired beside the CPU.
    localparam int EV_STALL = 0;
    localparam int EV_FLUSH = 1;

    // Width of a select able to address n event counters plus the cycle counter.
    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 ovf_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL = '1;

    // Count up on inc_i; at the maximum hold the value and latch the overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
            ovf_o   <= 1'b0;
        end else if (clr_i) begin
            count_o <= '0;
            ovf_o   <= 1'b0;
        end else if (inc_i) begin
            if (count_o == MAX_VAL) begin
                ovf_o <= 1'b1;
            end else begin
                count_o <= count_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_event_monitor.sv
// Cycle and pipeline-event monitor: FSM, count gating, saturating counters
// and a registered readout mux. Counting happens only on edges closing a
// cycle spent in RUN; clear_i overrides everything else.
module pipeline_event_monitor
    import pipeline_monitor_pkg::*;
#(
    parameter int NUM_EVENTS  = 2,
    parameter int CNT_WIDTH   = 32,
    parameter int CYCLE_LIMIT = 200,
    localparam int SEL_W      = sel_width(NUM_EVENTS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic [CNT_WIDTH-1:0]  rd_data_o,
    output logic                  running_o,
    output logic                  limit_reached_o,
    output logic [NUM_EVENTS:0]   overflow_o,
    output state_t                state_o
);

    state_t                state_q;
    state_t                state_d;
    logic                  count_en;
    logic                  limit_hit;
    logic [32:0]           cyc_next;
    logic [NUM_EVENTS:0]   inc;
    logic [NUM_EVENTS:0]   ovf;
    logic [CNT_WIDTH-1:0]  cnt [NUM_EVENTS+1];
    logic [CNT_WIDTH-1:0]  rd_next;

    // Counters advance only while RUN, and never on a clear edge.
    assign count_en = (state_q == RUN) && !clear_i;

    // Limit test uses the would-be cycle count, computed wide so a small
    // CNT_WIDTH cannot alias onto the limit.
    assign cyc_next  = 33'(cnt[0]) + 33'd1;
    assign limit_hit = (CYCLE_LIMIT != 0) && (cyc_next == 33'(CYCLE_LIMIT));

    assign inc[0] = count_en;
    for (genvar k = 1; k <= NUM_EVENTS; k++) begin : g_ev_inc
        assign inc[k] = count_en & event_i[k-1];
    end

    // Index 0 is the cycle counter, index k is event channel k-1.
    for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
        sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc_i   (inc[k]),
            .clr_i   (clear_i),
            .count_o (cnt[k]),
            .ovf_o   (ovf[k])
        );
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the limit takes priority over start_i dropping.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN: begin
                    if (limit_hit)     state_d = DONE;
                    else if (!start_i) state_d = PAUSE;
                end
                PAUSE:   if (start_i) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Readout select; anything past the last channel reads as zero.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k <= NUM_EVENTS; k++) begin
            if (rd_sel_i == SEL_W'(k)) rd_next = cnt[k];
        end
    end

    // Readout register loads every edge, including clear edges (pre-clear value).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_next;
        end
    end

    assign running_o       = (state_q == RUN);
    assign limit_reached_o = (state_q == DONE);
    assign overflow_o      = ovf;
    assign state_o         = state_q;

endmodule
